// File: rtl/cl_axi_sram_responder_if.sv
// AXI4 bus bundle for the SRAM responder: AW/W/B/AR/R channels,
// 64-bit address, 512-bit data, with master and slave modports.
interface axi_bus_t #(
  parameter int ID_W = 16
);
  logic [ID_W-1:0] awid;
  logic [63:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic            awvalid;
  logic            awready;
  logic [511:0]    wdata;
  logic [63:0]     wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [ID_W-1:0] arid;
  logic [63:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [511:0]    rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/cl_axi_sram_responder.sv
// AXI4 responder backed by 2^DEPTH_LOG2 x 512-bit SRAM lines.
// Ports: clk, rst_n (async, active-low), s_axi_bus (axi_bus_t.slave).
module cl_axi_sram_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int ID_W = 16
) (
  input logic      clk,
  input logic      rst_n,
  axi_bus_t.slave  s_axi_bus
);
  localparam int LINES = 1 << DEPTH_LOG2;
  localparam int XW = DEPTH_LOG2 + 9;

  typedef logic [DEPTH_LOG2-1:0] idx_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [511:0] mem [LINES];

  // Wide sum so idx + len can never wrap before the range compare.
  function automatic logic oor(
    input logic [63:6] a,
    input logic [7:0]  len,
    input logic [2:0]  size
  );
    logic [XW-1:0] last;
    last = XW'(a[6+DEPTH_LOG2-1:6]) + XW'(len);
    return (size != 3'd6)
        || (a[63:6+DEPTH_LOG2] != '0)
        || (last > XW'(LINES - 1));
  endfunction

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{s_axi_bus.awaddr[5:0],
                             s_axi_bus.araddr[5:0]};

  // Holds readies low until the first edge after reset release.
  logic up;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) up <= 1'b0;
    else        up <= 1'b1;
  end

  w_state_t        w_state, w_next;
  logic            aw_rdy, w_rdy, b_vld;
  logic            aw_hs, w_hs;
  logic [ID_W-1:0] w_id;
  idx_t            w_idx, w_addr;
  logic [7:0]      w_len, w_cnt;
  logic            w_err, w_cnt_last, w_end;

  assign aw_hs = aw_rdy && s_axi_bus.awvalid;
  assign w_hs  = w_rdy && s_axi_bus.wvalid;
  assign w_cnt_last = (w_cnt == w_len);
  assign w_end  = s_axi_bus.wlast || w_cnt_last;
  assign w_addr = w_idx + idx_t'(w_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    aw_rdy = 1'b0;
    w_rdy  = 1'b0;
    b_vld  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        aw_rdy = up;
        if (up && s_axi_bus.awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        w_rdy = 1'b1;
        if (s_axi_bus.wvalid && w_end) w_next = W_RESP;
      end
      W_RESP: begin
        b_vld = 1'b1;
        if (s_axi_bus.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_id  <= '0;
      w_idx <= '0;
      w_len <= '0;
      w_cnt <= '0;
      w_err <= 1'b0;
    end else if (aw_hs) begin
      w_id  <= s_axi_bus.awid;
      w_idx <= s_axi_bus.awaddr[6+DEPTH_LOG2-1:6];
      w_len <= s_axi_bus.awlen;
      w_cnt <= '0;
      w_err <= oor(s_axi_bus.awaddr[63:6],
                   s_axi_bus.awlen, s_axi_bus.awsize);
    end else if (w_hs) begin
      w_cnt <= w_cnt + 8'd1;
      // Early or missing wlast is only known on the final beat.
      if (w_end && (s_axi_bus.wlast != w_cnt_last))
        w_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && !w_err) begin
      for (int b = 0; b < 64; b++) begin
        if (s_axi_bus.wstrb[b])
          mem[w_addr][8*b +: 8] <= s_axi_bus.wdata[8*b +: 8];
      end
    end
  end

  assign s_axi_bus.awready = aw_rdy;
  assign s_axi_bus.wready  = w_rdy;
  assign s_axi_bus.bvalid  = b_vld;
  assign s_axi_bus.bid     = w_id;
  assign s_axi_bus.bresp   = {w_err, 1'b0};

  r_state_t        r_state, r_next;
  logic            ar_rdy, r_vld;
  logic            ar_hs, r_hs;
  logic [ID_W-1:0] r_id;
  idx_t            r_idx, ar_idx;
  logic [7:0]      r_len, r_cnt, r_nxt;
  logic            r_err, r_last, ar_err;
  logic [511:0]    r_data;

  assign ar_hs  = ar_rdy && s_axi_bus.arvalid;
  assign r_hs   = r_vld && s_axi_bus.rready;
  assign r_last = (r_cnt == r_len);
  assign r_nxt  = r_cnt + 8'd1;
  assign ar_idx = s_axi_bus.araddr[6+DEPTH_LOG2-1:6];
  assign ar_err = oor(s_axi_bus.araddr[63:6],
                      s_axi_bus.arlen, s_axi_bus.arsize);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    ar_rdy = 1'b0;
    r_vld  = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        ar_rdy = up;
        if (up && s_axi_bus.arvalid) r_next = R_DATA;
      end
      R_DATA: begin
        r_vld = 1'b1;
        if (s_axi_bus.rready && r_last) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // r_data is the prefetch register: it is loaded only when the
  // current beat is consumed, so a stalled beat stays put and the
  // next line is fetched exactly once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id   <= '0;
      r_idx  <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
      r_data <= '0;
    end else if (ar_hs) begin
      r_id   <= s_axi_bus.arid;
      r_idx  <= ar_idx;
      r_len  <= s_axi_bus.arlen;
      r_cnt  <= '0;
      r_err  <= ar_err;
      r_data <= ar_err ? '0 : mem[ar_idx];
    end else if (r_hs && !r_last) begin
      r_cnt  <= r_nxt;
      r_data <= r_err ? '0 : mem[r_idx + idx_t'(r_nxt)];
    end
  end

  assign s_axi_bus.arready = ar_rdy;
  assign s_axi_bus.rvalid  = r_vld;
  assign s_axi_bus.rid     = r_id;
  assign s_axi_bus.rresp   = {r_err, 1'b0};
  assign s_axi_bus.rlast   = r_vld && r_last;
  assign s_axi_bus.rdata   = r_data;
endmodule

// File: tb/tb_cl_axi_sram_responder.sv
// Self-checking bench for cl_axi_sram_responder: directed table,
// random bursts vs. a line-array model, stall and reset sequences.
module tb_cl_axi_sram_responder;
  localparam int D  = 10;
  localparam int N  = 1 << D;
  localparam int TO = 3000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_bus_t #(.ID_W(16)) bus ();

  cl_axi_sram_responder #(
    .DEPTH_LOG2(D),
    .ID_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_axi_bus(bus)
  );

  logic [511:0] model [N];
  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    bit          wr;
    logic [63:0] addr;
    int          len;
    logic [2:0]  size;
    int          wlast_at;
    logic [15:0] id;
    logic [63:0] strb;
    int          dmode;
    logic [1:0]  exp;
  } vec_t;

  task automatic chk(input string nm, input logic [531:0] act,
                     input logic [531:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    $display("FAIL %s: timeout waiting on DUT", nm);
  endtask

  function automatic bit oor(input logic [63:0] a, input int len,
                             input logic [2:0] size);
    int idx;
    idx = int'((a >> 6) % N);
    return size != 3'd6 || (a >> (6 + D)) != 0 || idx + len > N - 1;
  endfunction

  function automatic logic [511:0] beat(input int mode, input int k);
    logic [511:0] d;
    d = '0;
    case (mode)
      0: d = 512'(k);
      1: for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
      default: d = '1;
    endcase
    return d;
  endfunction

  task automatic idle();
    bus.awvalid = 0; bus.awid = '0; bus.awaddr = '0;
    bus.awlen = '0; bus.awsize = 3'd6;
    bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 0;
    bus.bready = 0;
    bus.arvalid = 0; bus.arid = '0; bus.araddr = '0;
    bus.arlen = '0; bus.arsize = 3'd6;
    bus.rready = 0;
  endtask

  task automatic do_write(input logic [63:0] addr, input int len,
      input logic [2:0] size, input int wlast_at,
      input logic [15:0] id, input logic [63:0] strb,
      input int dmode, input bit gaps, input logic [1:0] exp);
    int nb, t, idx;
    bit err;
    logic [511:0] d;
    err = oor(addr, len, size);
    idx = int'((addr >> 6) % N);
    nb = (wlast_at < len ? wlast_at : len) + 1;
    @(negedge clk);
    bus.awvalid = 1; bus.awid = id; bus.awaddr = addr;
    bus.awlen = 8'(len); bus.awsize = size;
    t = 0;
    while (!bus.awready && t < TO) begin @(negedge clk); t++; end
    if (t >= TO) begin timeout("aw"); idle(); return; end
    @(negedge clk);
    bus.awvalid = 0;
    for (int k = 0; k < nb; k++) begin
      if (gaps) repeat ($urandom % 3) begin
        bus.wvalid = 0; @(negedge clk);
      end
      d = beat(dmode, k);
      bus.wdata = d; bus.wstrb = strb;
      bus.wlast = (k == wlast_at); bus.wvalid = 1;
      t = 0;
      while (!bus.wready && t < TO) begin @(negedge clk); t++; end
      if (t >= TO) begin timeout("w"); idle(); return; end
      if (!err)
        for (int b = 0; b < 64; b++)
          if (strb[b]) model[idx + k][8*b +: 8] = d[8*b +: 8];
      @(negedge clk);
    end
    bus.wvalid = 0; bus.wlast = 0;
    t = 0;
    forever begin
      bus.bready = gaps ? 1'($urandom % 2) : 1'b1;
      if (bus.bvalid && bus.bready) break;
      if (t >= TO) begin timeout("b"); idle(); return; end
      @(negedge clk); t++;
    end
    chk("bid_bresp", {bus.bid, bus.bresp}, {id, exp});
    @(negedge clk);
    bus.bready = 0;
  endtask

  // mode 0: random rready, 1: 1,0,0,1 pattern, 2: always ready
  task automatic do_read(input logic [63:0] addr, input int len,
      input logic [2:0] size, input logic [15:0] id,
      input int mode, input logic [1:0] exp);
    int t, k, cyc, idx;
    bit have;
    logic [531:0] snap, cur;
    logic [511:0] ed;
    idx = int'((addr >> 6) % N);
    @(negedge clk);
    bus.arvalid = 1; bus.arid = id; bus.araddr = addr;
    bus.arlen = 8'(len); bus.arsize = size;
    t = 0;
    while (!bus.arready && t < TO) begin @(negedge clk); t++; end
    if (t >= TO) begin timeout("ar"); idle(); return; end
    @(negedge clk);
    bus.arvalid = 0;
    chk("r_latency", 532'(bus.rvalid), 532'(1));
    k = 0; cyc = 0; have = 0; t = 0;
    while (k <= len) begin
      case (mode)
        0: bus.rready = 1'($urandom % 2);
        1: bus.rready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: bus.rready = 1;
      endcase
      cur = {bus.rid, bus.rresp, bus.rlast, bus.rdata};
      if (have) chk("r_stall", cur, snap);
      have = 0;
      if (bus.rvalid && bus.rready) begin
        ed = (exp == 2'b10) ? '0 : model[(idx + k) % N];
        chk("r_data", 532'(bus.rdata), 532'(ed));
        chk("r_meta", 532'({bus.rid, bus.rresp, bus.rlast}),
            532'({id, exp, 1'(k == len)}));
        k++;
      end else if (bus.rvalid) begin
        snap = cur; have = 1;
      end
      if (t >= TO) begin timeout("r"); idle(); return; end
      @(negedge clk); cyc++; t++;
    end
    bus.rready = 0;
    chk("r_done", 532'(bus.rvalid), 532'(0));
  endtask

  function automatic vec_t mk(bit wr, logic [63:0] a, int len,
      logic [2:0] sz, int wl, logic [15:0] id, logic [63:0] st,
      int dm, logic [1:0] ex);
    vec_t v;
    v.wr = wr; v.addr = a; v.len = len; v.size = sz;
    v.wlast_at = wl; v.id = id; v.strb = st; v.dmode = dm;
    v.exp = ex;
    return v;
  endfunction

  vec_t tbl [17];

  initial begin
    logic [63:0] a;
    int len, wl;
    logic [2:0] sz;
    logic [1:0] ex;
    bit bseen;
    logic [511:0] d;

    for (int i = 0; i < N; i++) model[i] = '0;
    idle();

    tbl[0]  = mk(1, 64'h40, 3, 6, 3, 16'h1234, '1, 0, 2'b00);
    tbl[1]  = mk(0, 64'h40, 3, 6, 0, 16'h1234, '1, 0, 2'b00);
    tbl[2]  = mk(1, 64'd320, 0, 6, 0, 16'h0005, '1, 2, 2'b00);
    tbl[3]  = mk(1, 64'd320, 0, 6, 0, 16'h0006, 64'hFF, 0, 2'b00);
    tbl[4]  = mk(0, 64'd320, 0, 6, 0, 16'h0007, '1, 0, 2'b00);
    tbl[5]  = mk(1, 64'(1022*64), 3, 6, 3, 16'h0A0A, '1, 1, 2'b10);
    tbl[6]  = mk(0, 64'(1022*64), 3, 6, 0, 16'h0B0B, '1, 0, 2'b10);
    tbl[7]  = mk(0, 64'(1022*64), 1, 6, 0, 16'h0C0C, '1, 0, 2'b00);
    tbl[8]  = mk(1, 64'h1000, 3, 6, 1, 16'h0029, '1, 1, 2'b10);
    tbl[9]  = mk(0, 64'h1000, 3, 6, 0, 16'h002A, '1, 0, 2'b00);
    tbl[10] = mk(1, 64'h2000, 1, 6, 5, 16'h0030, '1, 1, 2'b10);
    tbl[11] = mk(1, 64'h3000, 0, 5, 0, 16'h0031, '1, 1, 2'b10);
    tbl[12] = mk(0, 64'h3000, 0, 7, 0, 16'h0032, '1, 0, 2'b10);
    tbl[13] = mk(0, 64'h1_0000_0040, 2, 6, 0, 16'h0033, '1, 0, 2'b10);
    tbl[14] = mk(0, 64'(1023*64), 0, 6, 0, 16'h0034, '1, 0, 2'b00);
    tbl[15] = mk(1, 64'(1023*64), 1, 6, 1, 16'h0035, '1, 1, 2'b10);
    tbl[16] = mk(1, 64'h80, 0, 6, 0, 16'hFFFF, '1, 1, 2'b00);

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_ctl", 532'({bus.awready, bus.wready, bus.bvalid,
        bus.arready, bus.rvalid, bus.rlast}), 532'(0));
    chk("reset_data", {bus.bid, bus.bresp, bus.rid, bus.rresp,
        bus.rdata}, '0);
    rst_n = 1;
    #1 chk("pre_edge_rdy", 532'({bus.awready, bus.arready}), 532'(0));
    @(posedge clk);
    #1 chk("post_edge_rdy", 532'({bus.awready, bus.arready}),
           532'(3));

    // fill every line so all later reads have known contents
    for (int i = 0; i < 4; i++)
      do_write(64'(i * 256 * 64), 255, 6, 255, 16'(i), '1, 1, 0,
               2'b00);
    do_read(64'(256 * 64), 255, 6, 16'h00AA, 2, 2'b00);

    for (int i = 0; i < 17; i++) begin
      if (tbl[i].wr)
        do_write(tbl[i].addr, tbl[i].len, tbl[i].size,
                 tbl[i].wlast_at, tbl[i].id, tbl[i].strb,
                 tbl[i].dmode, 1, tbl[i].exp);
      else
        do_read(tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].id,
                0, tbl[i].exp);
    end

    for (int i = 0; i < 60; i++) begin
      len = ($urandom % 8 == 0) ? int'($urandom % 64)
                                : int'($urandom % 8);
      sz = ($urandom % 8 == 0) ? 3'($urandom % 8) : 3'd6;
      a = {44'd0, 10'($urandom % N), 6'($urandom % 64)};
      if ($urandom % 16 == 0) a[40] = 1'b1;
      if ($urandom % 2 == 0) begin
        wl = ($urandom % 8 == 0) ? int'($urandom % (len + 3)) : len;
        ex = (oor(a, len, sz) || wl != len) ? 2'b10 : 2'b00;
        do_write(a, len, sz, wl, 16'($urandom), 64'({$urandom, $urandom}),
                 1, 1, ex);
      end else begin
        ex = oor(a, len, sz) ? 2'b10 : 2'b00;
        do_read(a, len, sz, 16'($urandom), 0, ex);
      end
    end

    // stalled read with rready 1,0,0,1
    do_read(64'h40 * 100, 7, 6, 16'h0BEE, 1, 2'b00);

    // reset during beat 2 of concurrent write and read
    @(negedge clk);
    bus.awvalid = 1; bus.awid = 16'h0077; bus.awaddr = 64'h4000;
    bus.awlen = 8'd7; bus.awsize = 3'd6;
    bus.arvalid = 1; bus.arid = 16'h0078; bus.araddr = 64'h8000;
    bus.arlen = 8'd7; bus.arsize = 3'd6;
    bus.rready = 1;
    chk("rst_seq_rdy", 532'({bus.awready, bus.arready}), 532'(3));
    @(negedge clk);
    bus.awvalid = 0; bus.arvalid = 0;
    for (int k = 0; k < 2; k++) begin
      d = beat(1, k);
      bus.wdata = d; bus.wstrb = '1; bus.wvalid = 1;
      chk("rst_seq_wrdy", 532'(bus.wready), 532'(1));
      model[256 + k] = d;
      @(negedge clk);
    end
    bus.wdata = beat(1, 2);
    rst_n = 0;
    #1 chk("rst_mid_ctl", 532'({bus.awready, bus.wready, bus.bvalid,
           bus.arready, bus.rvalid, bus.rlast}), 532'(0));
    chk("rst_mid_data", {bus.bid, bus.bresp, bus.rid, bus.rresp,
        bus.rdata}, '0);
    bus.wvalid = 0; bus.rready = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1 chk("rel_pre_edge", 532'({bus.awready, bus.arready}), 532'(0));
    @(posedge clk);
    #1 chk("rel_post_edge", 532'({bus.awready, bus.arready}), 532'(3));
    bseen = 0;
    bus.bready = 1;
    repeat (6) begin
      @(negedge clk);
      if (bus.bvalid || bus.rvalid) bseen = 1;
    end
    bus.bready = 0;
    chk("no_resp_after_rst", 532'(bseen), 532'(0));
    do_read(64'h4000, 3, 6, 16'h0079, 2, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
